keccak_arbiter: RTL and testbench

Message-granular round-robin arbiter that shares one `keccak_top` SHAKE core between `NREQ` requesters, for example the matrix-expansion sampler (SHAKE128) and the secret/challenge samplers (SHAKE256). It sits between the requesters' 64-bit FIFO-style streams and the core's `src_*`/`dst_*` ports. Ownership is granted for a whole transaction: the first input word through the last output word. Before each new owner, the block pulses the core reset so no absorb or squeeze state leaks between owners.

---
 rtl/keccak_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/keccak_arbiter.sv | 137 +++++++++++++
 tb/tb_keccak_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak/SHAKE sampler slice.
package keccak_pkg;

   localparam int unsigned KECCAK_WORD_W = 64;
   localparam int unsigned ARB_NREQ_MAX  = 4;
   localparam int unsigned ARB_IDX_W     = 2;

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      GRANT
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts just after the previous winner.
module rr_arbiter
   import keccak_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0]      req,
   input  logic [ARB_IDX_W-1:0] last,
   output logic [NREQ-1:0]      win,
   output logic                 any
);

   // Walk offsets from lowest to highest priority; the last hit (smallest offset) wins.
   always_comb begin
      win = '0;
      for (int off = int'(NREQ) - 1; off >= 0; off--) begin
         for (int k = 0; k < int'(NREQ); k++) begin
            if (req[k] && (k == ((int'(last) + 1 + off) % int'(NREQ)))) begin
               win    = '0;
               win[k] = 1'b1;
            end
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/keccak_arbiter.sv
// Message-granular round-robin arbiter sharing one SHAKE core between NREQ requesters.
module keccak_arbiter
   import keccak_pkg::*;
#(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NREQ-1:0]                 req,
   output logic [NREQ-1:0]                 gnt,
   output logic                            busy,
   input  logic [NREQ-1:0]                 src_ready,
   output logic [NREQ-1:0]                 src_read,
   input  logic [KECCAK_WORD_W*NREQ-1:0]   din,
   input  logic [NREQ-1:0]                 dst_ready,
   output logic [NREQ-1:0]                 dst_write,
   output logic [KECCAK_WORD_W-1:0]        dout,
   output logic                            core_rst,
   output logic                            core_src_ready,
   input  logic                            core_src_read,
   output logic [KECCAK_WORD_W-1:0]        core_din,
   output logic                            core_dst_ready,
   input  logic                            core_dst_write,
   input  logic [KECCAK_WORD_W-1:0]        core_dout,
   output logic [CNT_W-1:0]                in_cnt,
   output logic [CNT_W-1:0]                out_cnt,
   output logic                            drop_err
);

   arb_state_t             state_q, state_d;
   logic [NREQ-1:0]        gnt_q, gnt_d;
   logic [ARB_IDX_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]       in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
   logic                   core_rst_q;
   logic                   drop_err_q, drop_err_d;
   logic [NREQ-1:0]        win;
   logic                   any;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .req  (req),
      .last (last_q),
      .win  (win),
      .any  (any)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      in_cnt_d   = in_cnt_q;
      out_cnt_d  = out_cnt_q;
      drop_err_d = drop_err_q | (core_dst_write && (state_q != GRANT));
      unique case (state_q)
         IDLE: begin
            if (any) begin
               state_d   = FLUSH;
               gnt_d     = win;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               for (int k = 0; k < int'(NREQ); k++) begin
                  if (win[k]) last_d = ARB_IDX_W'(k);
               end
            end
         end
         FLUSH: begin
            state_d = GRANT;
         end
         GRANT: begin
            if (core_src_read && (in_cnt_q != '1)) in_cnt_d = in_cnt_q + 1'b1;
            if (core_dst_write && (out_cnt_q != '1)) out_cnt_d = out_cnt_q + 1'b1;
            // Owner releases by dropping its own request; other requests are ignored here.
            if (!(|(req & gnt_q))) begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         last_q     <= ARB_IDX_W'(NREQ - 1);
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         core_rst_q <= 1'b1;
         drop_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         core_rst_q <= (state_d == FLUSH);
         drop_err_q <= drop_err_d;
      end
   end

   // Zero-latency pass-through for the owner; everything is gated outside GRANT.
   always_comb begin
      core_src_ready = 1'b0;
      core_dst_ready = 1'b0;
      core_din       = '0;
      dout           = '0;
      src_read       = '0;
      dst_write      = '0;
      if (state_q == GRANT) begin
         dout = core_dout;
         for (int k = 0; k < int'(NREQ); k++) begin
            if (gnt_q[k]) begin
               core_src_ready = src_ready[k];
               core_din       = din[k*KECCAK_WORD_W +: KECCAK_WORD_W];
               core_dst_ready = dst_ready[k];
               src_read[k]    = core_src_read;
               dst_write[k]   = core_dst_write;
            end
         end
      end
   end

   assign gnt      = gnt_q;
   assign busy     = (state_q != IDLE);
   assign core_rst = core_rst_q;
   assign in_cnt   = in_cnt_q;
   assign out_cnt  = out_cnt_q;
   assign drop_err = drop_err_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_keccak_arbiter;

   localparam int NREQ  = 2;
   localparam int CNT_W = 16;
   localparam int NV    = 15;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic [NREQ-1:0]       src_ready = '0;
   logic [NREQ-1:0]       src_read;
   logic [64*NREQ-1:0]    din;
   logic [NREQ-1:0]       dst_ready = '0;
   logic [NREQ-1:0]       dst_write;
   logic [63:0]           dout;
   logic                  core_rst;
   logic                  core_src_ready;
   logic                  core_src_read = 1'b0;
   logic [63:0]           core_din;
   logic                  core_dst_ready;
   logic                  core_dst_write = 1'b0;
   logic [63:0]           core_dout;
   logic [CNT_W-1:0]      in_cnt;
   logic [CNT_W-1:0]      out_cnt;
   logic                  drop_err;

   logic [63:0] din_w [NREQ];
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  srdy;
      logic [1:0]  drdy;
      logic        crd;
      logic        cwr;
      logic [1:0]  e_gnt;
      logic        e_busy;
      logic        e_crst;
      logic        e_csr;
      logic        e_cdr;
      logic [1:0]  e_srd;
      logic [1:0]  e_dwr;
      logic [15:0] e_in;
      logic [15:0] e_out;
   } vec_t;

   vec_t v [NV];

   assign din_w[0]  = 64'hA5A5_0000_1111_0001;
   assign din_w[1]  = 64'h5A5A_2222_3333_0002;
   assign din       = {din_w[1], din_w[0]};
   assign core_dout = 64'hC0DE_F00D_1234_5678;

   always #5 clk = ~clk;

   keccak_arbiter #(
      .NREQ  (NREQ),
      .CNT_W (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst_n),
      .req            (req),
      .gnt            (gnt),
      .busy           (busy),
      .src_ready      (src_ready),
      .src_read       (src_read),
      .din            (din),
      .dst_ready      (dst_ready),
      .dst_write      (dst_write),
      .dout           (dout),
      .core_rst       (core_rst),
      .core_src_ready (core_src_ready),
      .core_src_read  (core_src_read),
      .core_din       (core_din),
      .core_dst_ready (core_dst_ready),
      .core_dst_write (core_dst_write),
      .core_dout      (core_dout),
      .in_cnt         (in_cnt),
      .out_cnt        (out_cnt),
      .drop_err       (drop_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_gnt();
      int n = 0;
      while (gnt == '0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (gnt == '0) begin
         errors++;
         $display("FAIL wait_gnt: got no grant, expected a grant within 8 cycles");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected run to finish");
      $fatal(1);
   end

   initial begin
      //        req    srdy   drdy  crd   cwr   gnt    busy  crst  csr   cdr   srd    dwr    in     out
      v[0]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0};
      v[1]  = '{2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0};
      v[2]  = '{2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0};
      v[3]  = '{2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 16'd0, 16'd0};
      v[4]  = '{2'b11, 2'b11, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 16'd1, 16'd0};
      v[5]  = '{2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2, 16'd1};
      v[6]  = '{2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 16'd2, 16'd1};
      v[7]  = '{2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2, 16'd1};
      v[8]  = '{2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0};
      v[9]  = '{2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 16'd0, 16'd0};
      v[10] = '{2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1, 16'd1};
      v[11] = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1, 16'd1};
      v[12] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0};
      v[13] = '{2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0};
      v[14] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0};

      // Reset values while reset is held.
      repeat (2) @(negedge clk);
      check("rst gnt", gnt, 0);
      check("rst busy", busy, 0);
      check("rst core_rst", core_rst, 1);
      check("rst in_cnt", in_cnt, 0);
      check("rst out_cnt", out_cnt, 0);
      check("rst drop_err", drop_err, 0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         req            = v[i].req;
         src_ready      = v[i].srdy;
         dst_ready      = v[i].drdy;
         core_src_read  = v[i].crd;
         core_dst_write = v[i].cwr;
         #1;
         check($sformatf("v%0d gnt", i), gnt, v[i].e_gnt);
         check($sformatf("v%0d busy", i), busy, v[i].e_busy);
         check($sformatf("v%0d core_rst", i), core_rst, v[i].e_crst);
         check($sformatf("v%0d core_src_ready", i), core_src_ready, v[i].e_csr);
         check($sformatf("v%0d core_dst_ready", i), core_dst_ready, v[i].e_cdr);
         check($sformatf("v%0d src_read", i), src_read, v[i].e_srd);
         check($sformatf("v%0d dst_write", i), dst_write, v[i].e_dwr);
         check($sformatf("v%0d in_cnt", i), in_cnt, v[i].e_in);
         check($sformatf("v%0d out_cnt", i), out_cnt, v[i].e_out);
         check($sformatf("v%0d drop_err", i), drop_err, 0);
      end

      // Core write while idle is dropped and latched as an error.
      @(negedge clk);
      core_dst_write = 1'b1;
      dst_ready      = 2'b11;
      #1;
      check("idle write dst_write", dst_write, 0);
      check("idle write dout", dout, 0);
      @(negedge clk);
      core_dst_write = 1'b0;
      check("drop_err set", drop_err, 1);
      req = 2'b01;
      @(negedge clk);
      check("drop grant gnt", gnt, 2'b01);
      check("drop_err sticky flush", drop_err, 1);
      @(negedge clk);

      // Output back-pressure for 10 cycles, then delivery.
      dst_ready = 2'b00;
      for (int i = 0; i < 10; i++) begin
         #1;
         check($sformatf("stall%0d core_dst_ready", i), core_dst_ready, 0);
         check($sformatf("stall%0d dst_write", i), dst_write, 0);
         @(negedge clk);
      end
      dst_ready      = 2'b01;
      core_dst_write = 1'b1;
      #1;
      check("deliver core_dst_ready", core_dst_ready, 1);
      check("deliver dst_write", dst_write, 2'b01);
      check("deliver dout", dout, 64'hC0DE_F00D_1234_5678);
      @(negedge clk);
      core_dst_write = 1'b0;
      #1;
      check("deliver out_cnt", out_cnt, 1);
      check("drop_err sticky grant", drop_err, 1);

      // Asynchronous reset in the middle of GRANT.
      rst_n = 1'b0;
      #1;
      check("async gnt", gnt, 0);
      check("async busy", busy, 0);
      check("async core_rst", core_rst, 1);
      check("async drop_err", drop_err, 0);
      check("async out_cnt", out_cnt, 0);
      check("async core_dst_ready", core_dst_ready, 0);

      // Both requesting: 21 words in, 4 out per transaction, grants alternate from 0.
      req       = 2'b11;
      src_ready = 2'b11;
      dst_ready = 2'b11;
      @(negedge clk);
      rst_n = 1'b1;
      wait_gnt();
      for (int t = 0; t < 4; t++) begin
         int own;
         own = t % 2;
         check($sformatf("rr%0d gnt", t), gnt, 64'(1) << own);
         check($sformatf("rr%0d flush core_rst", t), core_rst, 1);
         @(negedge clk);
         for (int i = 0; i < 21; i++) begin
            core_src_read = 1'b1;
            if (i == 0) begin
               #1;
               check($sformatf("rr%0d src_read", t), src_read, 64'(1) << own);
               check($sformatf("rr%0d core_din", t), core_din, din_w[own]);
            end
            @(negedge clk);
         end
         core_src_read = 1'b0;
         for (int i = 0; i < 4; i++) begin
            core_dst_write = 1'b1;
            @(negedge clk);
         end
         core_dst_write = 1'b0;
         check($sformatf("rr%0d in_cnt", t), in_cnt, 21);
         check($sformatf("rr%0d out_cnt", t), out_cnt, 4);
         req[own] = 1'b0;
         @(negedge clk);
         check($sformatf("rr%0d gap gnt", t), gnt, 0);
         check($sformatf("rr%0d gap busy", t), busy, 0);
         check($sformatf("rr%0d gap in_cnt", t), in_cnt, 21);
         req[own] = 1'b1;
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
